toy_mem_arbiter: RTL and testbench



---
 rtl/toy_pkg.sv | 27 ++
 rtl/toy_rd_tag_pipe.sv | 32 +++
 rtl/toy_mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_toy_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_pkg.sv
// Shared TOY memory definitions: bus widths, requester ids and the read-return tag.
package toy_pkg;

    localparam int MEM_AW = 8;
    localparam int MEM_DW = 16;

    typedef enum logic {
        REQ_CORE  = 1'b0,
        REQ_PANEL = 1'b1
    } req_id_t;

    localparam logic [MEM_AW-1:0] STDIO_ADDR = 8'hFF;

    typedef struct packed {
        logic    valid;
        req_id_t owner;
    } rd_tag_t;

    function automatic logic [1:0] req_onehot(input req_id_t id);
        if (id == REQ_PANEL) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

endpackage

// File: rtl/toy_rd_tag_pipe.sv
// Fixed-latency shift pipe carrying {valid, owner} for each accepted read so the
// returning RAM data can be steered to the requester that issued it.
module toy_rd_tag_pipe
    import toy_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t pipe_q [DEPTH];

    // Shift register; reset flushes every stage so no stale return survives.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/toy_mem_arbiter.sv
// Two-requester arbiter (core / front panel) for the single TOY main-memory port.
// Optional grant locking is compiled in with the macro TOY_MEM_ARB_LOCK_EN.
module toy_mem_arbiter
    import toy_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int PANEL_PRIO  = 1,
    parameter int WAIT_MAX    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             req_i,
    input  logic [1:0]             we_i,
    input  logic [1:0][MEM_AW-1:0] addr_i,
    input  logic [1:0][MEM_DW-1:0] wdata_i,
    input  logic [1:0]             lock_i,
    output logic [1:0]             gnt_o,
    output logic [1:0]             rvalid_o,
    output logic [MEM_DW-1:0]      rdata_o,
    output logic                   mem_en_o,
    output logic                   mem_we_o,
    output logic [MEM_AW-1:0]      mem_addr_o,
    output logic [MEM_DW-1:0]      mem_wdata_o,
    input  logic [MEM_DW-1:0]      mem_rdata_i,
    output logic [1:0]             starve_o
);

    localparam logic [7:0] WAIT_MAX_C   = 8'(WAIT_MAX);
    localparam logic       PANEL_PRIO_C = (PANEL_PRIO != 0);

    logic [1:0]        gnt_s;
    logic              gnt_idx_s;
    logic              force_gnt_s;
    logic [1:0]        lock_gnt_s;
    logic [1:0][7:0]   wait_q, wait_d;
    logic              rr_q, rr_d;
    logic [1:0]        starve_q, starve_d;
    logic [MEM_DW-1:0] rdata_q;
    rd_tag_t           tag_in_s, tag_out_s;

    assign gnt_idx_s = gnt_s[1];

`ifdef TOY_MEM_ARB_LOCK_EN
    logic       lock_q, lock_d;
    logic       lock_own_q, lock_own_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;

    // A lock that has already held WAIT_MAX grants sits out one arbitration.
    assign lock_gnt_s = (lock_q && req_i[lock_own_q] && (lock_cnt_q != WAIT_MAX_C))
                        ? req_onehot(req_id_t'(lock_own_q)) : 2'b00;

    // Lock ownership follows the granted requester's lock_i.
    always_comb begin
        lock_d     = lock_q;
        lock_own_d = lock_own_q;
        lock_cnt_d = lock_cnt_q;
        if (gnt_s == 2'b00) begin
            lock_d     = 1'b0;
            lock_cnt_d = 8'd0;
        end else if (lock_i[gnt_idx_s]) begin
            lock_d     = 1'b1;
            lock_own_d = gnt_idx_s;
            if (lock_gnt_s != 2'b00) begin
                lock_cnt_d = lock_cnt_q + 8'd1;
            end else begin
                lock_cnt_d = 8'd1;
            end
        end else begin
            lock_d     = 1'b0;
            lock_cnt_d = 8'd0;
        end
    end

    // Lock state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_own_q <= 1'b0;
            lock_cnt_q <= 8'd0;
        end else begin
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    logic lock_unused_s;
    assign lock_gnt_s    = 2'b00;
    assign lock_unused_s = ^lock_i;
`endif

    // Arbitration: lock, then starvation (core first), then priority / round-robin.
    always_comb begin
        gnt_s       = 2'b00;
        force_gnt_s = 1'b0;
        if (rst_i) begin
            gnt_s = 2'b00;
        end else if (lock_gnt_s != 2'b00) begin
            gnt_s = lock_gnt_s;
        end else if (req_i[0] && (wait_q[0] == WAIT_MAX_C)) begin
            gnt_s       = 2'b01;
            force_gnt_s = 1'b1;
        end else if (req_i[1] && (wait_q[1] == WAIT_MAX_C)) begin
            gnt_s       = 2'b10;
            force_gnt_s = 1'b1;
        end else if (req_i == 2'b11) begin
            if (PANEL_PRIO_C || rr_q) begin
                gnt_s = 2'b10;
            end else begin
                gnt_s = 2'b01;
            end
        end else begin
            gnt_s = req_i;
        end
    end

    // Memory port driven straight from the winner so the access issues with the grant.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt_s != 2'b00) begin
            mem_en_o    = 1'b1;
            mem_we_o    = we_i[gnt_idx_s];
            mem_addr_o  = addr_i[gnt_idx_s];
            mem_wdata_o = wdata_i[gnt_idx_s];
        end else begin
            mem_en_o = 1'b0;
        end
    end

    // Wait counters, sticky starvation flags and round-robin pointer (1 = panel first).
    always_comb begin
        wait_d   = wait_q;
        starve_d = starve_q;
        rr_d     = rr_q;
        for (int i = 0; i < 2; i++) begin
            if (!req_i[i] || gnt_s[i]) begin
                wait_d[i] = 8'd0;
            end else if (wait_q[i] != WAIT_MAX_C) begin
                wait_d[i] = wait_q[i] + 8'd1;
            end else begin
                wait_d[i] = wait_q[i];
            end
        end
        if (force_gnt_s) begin
            starve_d = starve_q | gnt_s;
        end else begin
            starve_d = starve_q;
        end
        if (gnt_s != 2'b00) begin
            rr_d = gnt_s[0];
        end else begin
            rr_d = rr_q;
        end
    end

    assign tag_in_s.valid = (gnt_s != 2'b00) && !we_i[gnt_idx_s];
    assign tag_in_s.owner = req_id_t'(gnt_idx_s);

    toy_rd_tag_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_tag_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tag_i (tag_in_s),
        .tag_o (tag_out_s)
    );

    // Return data passes through in the return cycle and is held afterwards.
    always_comb begin
        rvalid_o = 2'b00;
        rdata_o  = rdata_q;
        if (tag_out_s.valid) begin
            rvalid_o = req_onehot(tag_out_s.owner);
            rdata_o  = mem_rdata_i;
        end else begin
            rdata_o = rdata_q;
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_q   <= '0;
            rr_q     <= 1'b0;
            starve_q <= 2'b00;
            rdata_q  <= '0;
        end else begin
            wait_q   <= wait_d;
            rr_q     <= rr_d;
            starve_q <= starve_d;
            rdata_q  <= rdata_o;
        end
    end

    assign gnt_o    = gnt_s;
    assign starve_o = starve_q;

endmodule

// File: tb/tb_toy_mem_arbiter.sv
// Scoreboard bench for toy_mem_arbiter: dut0 = latency 1 / panel priority,
// dut1 = latency 3 / round-robin; the bench models the synchronous RAMs.
module tb_toy_mem_arbiter;

    typedef struct {
        logic [1:0]  rv;
        logic [15:0] data;
        int          cyc;
    } rexp_t;

    logic clk = 1'b0;
    logic rst;
    logic ram_load;
    int   tcyc = 0;
    int   vecs = 0;
    int   errs = 0;

    logic [1:0]       req_s [2];
    logic [1:0]       we_s [2];
    logic [1:0]       lock_s [2];
    logic [1:0][7:0]  addr_s [2];
    logic [1:0][15:0] wdata_s [2];
    logic [1:0]       gnt_s [2];
    logic [1:0]       rvalid_s [2];
    logic [1:0]       starve_s [2];
    logic [15:0]      rdata_s [2];
    logic             mem_en_s [2];
    logic             mem_we_s [2];
    logic [7:0]       mem_addr_s [2];
    logic [15:0]      mem_wdata_s [2];
    logic [15:0]      mem_rdata_s [2];

    logic [15:0] ram [2][256];
    logic [15:0] rpipe [2][3];

    rexp_t      rq [2][$];
    logic [1:0] gq [2][$];

    always #5 clk = ~clk;

    always @(posedge clk) tcyc <= tcyc + 1;

    toy_mem_arbiter #(.MEM_LATENCY(1), .PANEL_PRIO(1), .WAIT_MAX(8)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req_s[0]), .we_i(we_s[0]), .addr_i(addr_s[0]),
        .wdata_i(wdata_s[0]), .lock_i(lock_s[0]), .gnt_o(gnt_s[0]), .rvalid_o(rvalid_s[0]),
        .rdata_o(rdata_s[0]), .mem_en_o(mem_en_s[0]), .mem_we_o(mem_we_s[0]),
        .mem_addr_o(mem_addr_s[0]), .mem_wdata_o(mem_wdata_s[0]),
        .mem_rdata_i(mem_rdata_s[0]), .starve_o(starve_s[0]));

    toy_mem_arbiter #(.MEM_LATENCY(3), .PANEL_PRIO(0), .WAIT_MAX(8)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req_s[1]), .we_i(we_s[1]), .addr_i(addr_s[1]),
        .wdata_i(wdata_s[1]), .lock_i(lock_s[1]), .gnt_o(gnt_s[1]), .rvalid_o(rvalid_s[1]),
        .rdata_o(rdata_s[1]), .mem_en_o(mem_en_s[1]), .mem_we_o(mem_we_s[1]),
        .mem_addr_o(mem_addr_s[1]), .mem_wdata_o(mem_wdata_s[1]),
        .mem_rdata_i(mem_rdata_s[1]), .starve_o(starve_s[1]));

    function automatic logic [15:0] init_word(input int a);
        case (a)
            16:      return 16'h1234;
            32:      return 16'hBEEF;
            33:      return 16'hCAFE;
            default: return 16'h0000;
        endcase
    endfunction

    // Synchronous RAM models with 1- and 3-cycle read latency.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ram_load) begin
                for (int a = 0; a < 256; a++) ram[d][a] <= init_word(a);
            end else if (mem_en_s[d] && mem_we_s[d]) begin
                ram[d][mem_addr_s[d]] <= mem_wdata_s[d];
            end
            if (mem_en_s[d] && !mem_we_s[d]) rpipe[d][0] <= ram[d][mem_addr_s[d]];
            rpipe[d][1] <= rpipe[d][0];
            rpipe[d][2] <= rpipe[d][1];
        end
    end

    assign mem_rdata_s[0] = rpipe[0][0];
    assign mem_rdata_s[1] = rpipe[1][2];

    // Monitor: pops expected grants every driven cycle and read returns on rvalid.
    always @(negedge clk) begin
        logic [1:0] eg;
        rexp_t      e;
        for (int d = 0; d < 2; d++) begin
            if (gq[d].size() != 0) begin
                eg = gq[d].pop_front();
                vecs++;
                if (gnt_s[d] !== eg) begin
                    errs++;
                    $display("FAIL gnt dut%0d cyc %0d: got %b want %b", d, tcyc, gnt_s[d], eg);
                end
            end
            if (rvalid_s[d] != 2'b00) begin
                vecs++;
                if (rq[d].size() == 0) begin
                    errs++;
                    $display("FAIL rvalid_unexpected dut%0d cyc %0d: got %b want 00", d, tcyc, rvalid_s[d]);
                end else begin
                    e = rq[d].pop_front();
                    if (rvalid_s[d] !== e.rv || rdata_s[d] !== e.data || tcyc != e.cyc) begin
                        errs++;
                        $display("FAIL rdata dut%0d: got rv=%b data=%h cyc=%0d want rv=%b data=%h cyc=%0d",
                                 d, rvalid_s[d], rdata_s[d], tcyc, e.rv, e.data, e.cyc);
                    end
                end
            end else if (rq[d].size() != 0 && rq[d][0].cyc <= tcyc) begin
                vecs++;
                errs++;
                $display("FAIL rvalid_missing dut%0d cyc %0d: got 00 want %b", d, tcyc, rq[d][0].rv);
                void'(rq[d].pop_front());
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic drv(input int d, input logic [1:0] req, input logic [1:0] we,
                       input logic [1:0] lock, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [15:0] w0, input logic [1:0] eg, input logic [15:0] ed,
                       input bit push_rd);
        rexp_t e;
        @(posedge clk);
        #1;
        req_s[d]      = req;
        we_s[d]       = we;
        lock_s[d]     = lock;
        addr_s[d][0]  = a0;
        addr_s[d][1]  = a1;
        wdata_s[d][0] = w0;
        wdata_s[d][1] = 16'h0000;
        gq[d].push_back(eg);
        if (push_rd && eg != 2'b00 && (we & eg) == 2'b00) begin
            e.rv   = eg;
            e.data = ed;
            e.cyc  = tcyc + ((d == 0) ? 1 : 3);
            rq[d].push_back(e);
        end
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) drv(d, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 2'b00, 16'h0000, 1'b0);
    endtask

    function automatic logic [63:0] rst_view(input int d);
        return 64'({gnt_s[d], rvalid_s[d], starve_s[d], mem_en_s[d], mem_we_s[d],
                    rdata_s[d], mem_addr_s[d], mem_wdata_s[d]});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        ram_load = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_s[d]   = 2'b11;
            we_s[d]    = 2'b11;
            lock_s[d]  = 2'b00;
            addr_s[d]  = {8'h21, 8'h10};
            wdata_s[d] = {16'h5555, 16'hAAAA};
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_dut0", rst_view(0), 64'h0);
        chk("reset_dut1", rst_view(1), 64'h0);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            req_s[d]   = 2'b00;
            we_s[d]    = 2'b00;
            addr_s[d]  = '0;
            wdata_s[d] = '0;
        end
        rst      = 1'b0;
        ram_load = 1'b0;

        // Single core read of 0x10, latency 1.
        drv(0, 2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 16'h0000, 2'b01, 16'h1234, 1'b1);
        idle(0, 2);
        @(negedge clk);
        chk("rdata_hold", 64'(rdata_s[0]), 64'h1234);
        chk("starve_none", 64'(starve_s[0]), 64'h0);

        // Panel priority: panel wins 8 cycles, core force-granted on the ninth.
        for (int i = 0; i < 8; i++)
            drv(0, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 16'h0000, 2'b10, 16'hBEEF, 1'b1);
        drv(0, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 16'h0000, 2'b01, 16'h1234, 1'b1);
        idle(0, 2);
        @(negedge clk);
        chk("starve_core", 64'(starve_s[0]), 64'h1);

        // Round-robin alternation, latency 3.
        for (int i = 0; i < 6; i++)
            drv(1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 16'h0000,
                (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 16'h1234 : 16'hBEEF, 1'b1);
        idle(1, 4);
        @(negedge clk);
        chk("starve_rr", 64'(starve_s[1]), 64'h0);

        // Back-to-back panel then core read, latency 3.
        drv(1, 2'b10, 2'b00, 2'b00, 8'h00, 8'h20, 16'h0000, 2'b10, 16'hBEEF, 1'b1);
        drv(1, 2'b01, 2'b00, 2'b00, 8'h21, 8'h00, 16'h0000, 2'b01, 16'hCAFE, 1'b1);
        idle(1, 4);

        // Core write 0xAB to 0x30 with lock_i, then read it back while panel requests.
        drv(0, 2'b01, 2'b01, 2'b01, 8'h30, 8'h20, 16'h00AB, 2'b01, 16'h0000, 1'b1);
`ifdef TOY_MEM_ARB_LOCK_EN
        drv(0, 2'b11, 2'b00, 2'b00, 8'h30, 8'h20, 16'h0000, 2'b01, 16'h00AB, 1'b1);
        drv(0, 2'b10, 2'b00, 2'b00, 8'h30, 8'h20, 16'h0000, 2'b10, 16'hBEEF, 1'b1);
`else
        drv(0, 2'b11, 2'b00, 2'b00, 8'h30, 8'h20, 16'h0000, 2'b10, 16'hBEEF, 1'b1);
        drv(0, 2'b01, 2'b00, 2'b00, 8'h30, 8'h20, 16'h0000, 2'b01, 16'h00AB, 1'b1);
`endif
        idle(0, 2);

        // Core read granted, reset pulsed next cycle: its return must never appear.
        drv(0, 2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 16'h0000, 2'b01, 16'h1234, 1'b0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_s[0]  = 2'b11;
        addr_s[0] = {8'h20, 8'h10};
        @(negedge clk);
        chk("midrst_dut0", rst_view(0), 64'h0);
        chk("midrst_dut1", rst_view(1), 64'h0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_s[0]  = 2'b00;
        addr_s[0] = '0;
        idle(0, 3);

        // Round-robin pointer restarts at the core after reset.
        drv(1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 16'h0000, 2'b01, 16'h1234, 1'b1);
        drv(1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 16'h0000, 2'b10, 16'hBEEF, 1'b1);
        idle(1, 5);

        @(negedge clk);
        chk("drain_dut0", 64'(rq[0].size()), 64'h0);
        chk("drain_dut1", 64'(rq[1].size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
